// File: rtl/stim_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stim_seq_pkg                                                               |
// | Opcode/state encodings and width helpers for the stimulus sequencer.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package stim_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_SET      = 3'd1,
    OP_SEND     = 3'd2,
    OP_SEND_BLK = 3'd3,
    OP_WAIT     = 3'd4,
    OP_END      = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DELAY = 3'd3,
    ST_SENDW = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Entry layout is {op, ch, arg}: these give the low bit of each upper field.
  function automatic int ch_lsb(input int dw);
    return dw;
  endfunction

  function automatic int op_lsb(input int dw, input int cw);
    return dw + cw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stim_seq_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stim_seq_mem                                                               |
// | Single-write, synchronous-read script RAM (contents are never reset).      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module stim_seq_mem #(
  parameter int DEPTH = 32,
  parameter int EW    = 21,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [EW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [EW-1:0] o_rdata
);

  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/stim_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stim_sequencer                                                             |
// | Script-driven stimulus/UART-command sequencer: SET, SEND, SEND_BLK, WAIT.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module stim_sequencer
  import stim_seq_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 2**20,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = ch_width(NCH),
  localparam int EW     = OP_W + CW + DW
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [EW-1:0]     wr_data,
  input  logic              start,
  input  logic              abort,
  input  logic              cmd_sent,
  output logic [7:0]        cmd,
  output logic              send_cmd,
  output logic [NCH*DW-1:0] chan_val,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AW-1:0]     pc
);

  localparam int              CNTW      = max_int(DW, $clog2(TIMEOUT + 1));
  localparam logic [AW-1:0]   c_last_pc = AW'(DEPTH - 1);
  localparam logic [CNTW-1:0] c_to_last = CNTW'(TIMEOUT - 1);

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_pc;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic [EW-1:0]   w_rd_data;
  logic [DW-1:0]   r_chan [NCH];
  logic [7:0]      r_cmd;
  logic            r_send, r_done, r_err, r_sent_prev;
  logic            w_send_nxt, w_done_nxt, w_err_set, w_err_clr;
  logic            w_pc_clr, w_pc_inc, w_chan_we, w_cmd_ld, w_adv;
  logic [2:0]      w_op;
  logic [CW-1:0]   w_ch;
  logic [DW-1:0]   w_arg;
  logic            w_ch_bad, w_rise;

  stim_seq_mem #(.DEPTH(DEPTH), .EW(EW)) u_mem (
    .clk     (clk),
    .i_we    (wr_en && (r_state == ST_IDLE)),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (r_pc),
    .o_rdata (w_rd_data)
  );

  assign w_op     = w_rd_data[op_lsb(DW, CW) +: OP_W];
  assign w_ch     = w_rd_data[ch_lsb(DW) +: CW];
  assign w_arg    = w_rd_data[DW-1:0];
  assign w_ch_bad = (int'(w_ch) >= NCH);
  // Only a rise seen while the request is already up counts as completion.
  assign w_rise   = cmd_sent && !r_sent_prev && r_send;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_send_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    w_pc_clr    = 1'b0;
    w_pc_inc    = 1'b0;
    w_chan_we   = 1'b0;
    w_cmd_ld    = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_FETCH;
        w_pc_clr    = 1'b1;
        w_err_clr   = 1'b1;
      end
      ST_FETCH: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        case (w_op)
          OP_NOP: w_adv = 1'b1;
          OP_SET: if (w_ch_bad) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_chan_we = 1'b1;
            w_adv     = 1'b1;
          end
          OP_SEND: begin
            w_cmd_ld   = 1'b1;
            w_send_nxt = 1'b1;
            w_adv      = 1'b1;
          end
          OP_SEND_BLK: begin
            w_cmd_ld    = 1'b1;
            w_send_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SENDW;
          end
          OP_WAIT: if (w_arg == '0) begin
            w_adv = 1'b1;
          end else begin
            w_cnt_nxt   = CNTW'(w_arg);
            w_state_nxt = ST_DELAY;
          end
          OP_END: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
          default: begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
      ST_DELAY: begin
        w_cnt_nxt = r_cnt - CNTW'(1);
        if (r_cnt == CNTW'(1)) w_adv = 1'b1;
      end
      ST_SENDW: begin
        if (w_rise) begin
          w_adv = 1'b1;
        end else if (r_cnt == c_to_last) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_send_nxt = 1'b1;
          w_cnt_nxt  = r_cnt + CNTW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Finishing the last entry ends the script; pc never wraps.
    if (w_adv) begin
      if (r_pc == c_last_pc) begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_pc_inc    = 1'b1;
        w_state_nxt = ST_FETCH;
      end
    end

    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_send_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_set   = 1'b0;
      w_err_clr   = 1'b0;
      w_pc_clr    = 1'b0;
      w_pc_inc    = 1'b0;
      w_chan_we   = 1'b0;
      w_cmd_ld    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_pc        <= '0;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_send      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sent_prev <= 1'b0;
      for (int k = 0; k < NCH; k++) r_chan[k] <= '0;
    end else begin
      r_sent_prev <= cmd_sent;
      r_send      <= w_send_nxt;
      r_done      <= w_done_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_pc_clr)      r_pc <= '0;
      else if (w_pc_inc) r_pc <= r_pc + AW'(1);
      if (w_err_clr)      r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      if (w_cmd_ld) r_cmd <= w_arg[7:0];
      for (int k = 0; k < NCH; k++) begin
        if (w_chan_we && (int'(w_ch) == k)) r_chan[k] <= w_arg;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign chan_val[k*DW +: DW] = r_chan[k];
  end

  assign cmd      = r_cmd;
  assign send_cmd = r_send;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign pc       = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_stim_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stim_sequencer                                                          |
// | Random and directed scripts against a per-entry timeline reference model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_stim_sequencer;

  localparam int NCH = 3, DW = 16, DEPTH = 32, TIMEOUT = 100;
  localparam int AW = 5, CW = 2, EW = 21, MAXC = 4096;

  logic clk = 1'b0, RST = 1'b1, wr_en = 1'b0, start = 1'b0, abort = 1'b0, cmd_sent = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [EW-1:0]     wr_data = '0;
  logic [7:0]        cmd;
  logic              send_cmd, busy, done, err;
  logic [NCH*DW-1:0] chan_val;
  logic [AW-1:0]     pc;

  stim_sequencer #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .cmd_sent(cmd_sent), .cmd(cmd), .send_cmd(send_cmd),
    .chan_val(chan_val), .busy(busy), .done(done), .err(err), .pc(pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  // Script image and per-entry cmd_sent delay (>= TIMEOUT means never answered)
  logic [2:0]    s_op  [DEPTH];
  logic [CW-1:0] s_ch  [DEPTH];
  logic [DW-1:0] s_arg [DEPTH];
  int            s_dly [DEPTH];

  // Reference state and expected per-cycle timeline
  logic [DW-1:0]     m_chan [NCH];
  logic [7:0]        m_cmd = '0;
  bit                m_err = 1'b0;
  int                n_exp;
  bit                e_busy [MAXC], e_send [MAXC], e_done [MAXC], e_err [MAXC], drv [MAXC];
  logic [7:0]        e_cmd  [MAXC];
  logic [NCH*DW-1:0] e_chan [MAXC];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] pack_chan();
    logic [NCH*DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = m_chan[k];
    return v;
  endfunction

  task automatic set_entry(input int i, input logic [2:0] op, input logic [CW-1:0] ch,
                           input logic [DW-1:0] arg, input int dly);
    s_op[i] = op; s_ch[i] = ch; s_arg[i] = arg; s_dly[i] = dly;
  endtask

  task automatic clear_script();
    for (int i = 0; i < DEPTH; i++) set_entry(i, 3'd0, '0, '0, 0);
  endtask

  task automatic load_script();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = {s_op[i], s_ch[i], s_arg[i]};
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rec(input bit b, input bit s, input bit d, input bit e);
    e_busy[n_exp] = b; e_send[n_exp] = s; e_done[n_exp] = d; e_err[n_exp] = e;
    e_cmd[n_exp] = m_cmd; e_chan[n_exp] = pack_chan();
    n_exp++;
  endtask

  // Every entry costs a fetch and an execute cycle; effects show in the cycle after execute.
  task automatic build_expect();
    bit pulse = 1'b0, fin = 1'b0, ok = 1'b0;
    int p = 0;
    n_exp = 0;
    m_err = 1'b0;
    for (int i = 0; i < MAXC; i++) drv[i] = 1'b0;
    while (!fin) begin
      rec(1'b1, pulse, 1'b0, 1'b0);
      pulse = 1'b0;
      rec(1'b1, 1'b0, 1'b0, 1'b0);
      case (s_op[p])
        3'd0: ;
        3'd1: if (int'(s_ch[p]) >= NCH) begin m_err = 1'b1; fin = 1'b1; end
              else m_chan[int'(s_ch[p])] = s_arg[p];
        3'd2: begin m_cmd = s_arg[p][7:0]; pulse = 1'b1; end
        3'd3: begin
          m_cmd = s_arg[p][7:0];
          if (s_dly[p] < TIMEOUT) begin
            drv[n_exp + s_dly[p]] = 1'b1;
            repeat (s_dly[p] + 1) rec(1'b1, 1'b1, 1'b0, 1'b0);
          end else begin
            repeat (TIMEOUT) rec(1'b1, 1'b1, 1'b0, 1'b0);
            m_err = 1'b1; fin = 1'b1;
          end
        end
        3'd4: repeat (int'(s_arg[p])) rec(1'b1, 1'b0, 1'b0, 1'b0);
        3'd5: begin ok = 1'b1; fin = 1'b1; end
        default: begin m_err = 1'b1; fin = 1'b1; end
      endcase
      if (!fin) begin
        if (p == DEPTH - 1) begin ok = 1'b1; fin = 1'b1; end
        else p++;
      end
    end
    rec(1'b0, pulse, ok, m_err);
  endtask

  task automatic run_and_check(input string tag);
    build_expect();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int t = 0; t < n_exp; t++) begin
      check_val($sformatf("%s busy@%0d", tag, t), 64'(busy),     64'(e_busy[t]));
      check_val($sformatf("%s send@%0d", tag, t), 64'(send_cmd), 64'(e_send[t]));
      check_val($sformatf("%s done@%0d", tag, t), 64'(done),     64'(e_done[t]));
      check_val($sformatf("%s err@%0d",  tag, t), 64'(err),      64'(e_err[t]));
      check_val($sformatf("%s cmd@%0d",  tag, t), 64'(cmd),      64'(e_cmd[t]));
      check_val($sformatf("%s chan@%0d", tag, t), 64'(chan_val), 64'(e_chan[t]));
      cmd_sent = drv[t];
      @(negedge clk);
    end
    cmd_sent = 1'b0;
    check_val({tag, " idle_busy"}, 64'(busy), 64'(0));
    check_val({tag, " idle_done"}, 64'(done), 64'(0));
    check_val({tag, " idle_err"},  64'(err),  64'(m_err));
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, " busy"}, 64'(busy),     64'(0));
    check_val({tag, " send"}, 64'(send_cmd), 64'(0));
    check_val({tag, " done"}, 64'(done),     64'(0));
    check_val({tag, " chan"}, 64'(chan_val), 64'(pack_chan()));
    check_val({tag, " cmd"},  64'(cmd),      64'(m_cmd));
  endtask

  task automatic random_script(input bit no_stop);
    for (int i = 0; i < DEPTH; i++) begin
      int k = no_stop ? $urandom_range(0, 89) : $urandom_range(0, 99);
      if (k < 10)      set_entry(i, 3'd0, CW'($urandom), DW'($urandom), 0);
      else if (k < 36) set_entry(i, 3'd1,
                         ($urandom_range(0, 19) == 0 && !no_stop) ? CW'(NCH) : CW'($urandom_range(0, NCH-1)),
                         DW'($urandom), 0);
      else if (k < 52) set_entry(i, 3'd2, '0, DW'($urandom), 0);
      else if (k < 67) set_entry(i, 3'd3, '0, DW'($urandom),
                         ($urandom_range(0, 24) == 0 && !no_stop) ? TIMEOUT + 7 : $urandom_range(0, 12));
      else if (k < 90) set_entry(i, 3'd4, '0, DW'($urandom_range(0, 6)), 0);
      else if (k < 97) set_entry(i, 3'd5, '0, '0, 0);
      else             set_entry(i, 3'($urandom_range(6, 7)), '0, '0, 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NCH; k++) m_chan[k] = '0;
    repeat (2) @(negedge clk);
    check_val("rst busy", 64'(busy), 64'(0));
    check_val("rst send", 64'(send_cmd), 64'(0));
    check_val("rst done", 64'(done), 64'(0));
    check_val("rst err",  64'(err), 64'(0));
    check_val("rst cmd",  64'(cmd), 64'(0));
    check_val("rst chan", 64'(chan_val), 64'(0));
    check_val("rst pc",   64'(pc), 64'(0));
    RST = 1'b0;

    // SET / WAIT 5 / SET / END
    clear_script();
    set_entry(0, 3'd1, 2'd0, 16'h0FFF, 0);
    set_entry(1, 3'd4, 2'd0, 16'd5, 0);
    set_entry(2, 3'd1, 2'd0, 16'h0000, 0);
    set_entry(3, 3'd5, 2'd0, 16'h0000, 0);
    load_script();
    run_and_check("setwait");

    // Blocking send answered 40 cycles in, then a plain send that ignores cmd_sent
    clear_script();
    set_entry(0, 3'd3, 2'd0, 16'h0047, 40);
    set_entry(1, 3'd2, 2'd0, 16'h0053, 0);
    set_entry(2, 3'd0, 2'd0, 16'h0000, 0);
    set_entry(3, 3'd5, 2'd0, 16'h0000, 0);
    load_script();
    run_and_check("send");

    // Blocking send never answered -> timeout; the next start clears err
    clear_script();
    set_entry(0, 3'd3, 2'd0, 16'h00A5, TIMEOUT + 50);
    load_script();
    run_and_check("timeout");
    clear_script();
    set_entry(0, 3'd5, 2'd0, 16'h0000, 0);
    load_script();
    run_and_check("errclr");

    // Channel index out of range, illegal opcode, and a script with no END
    clear_script();
    set_entry(0, 3'd1, 2'd2, 16'h0005, 0);
    set_entry(1, 3'd1, 2'(NCH), 16'hBEEF, 0);
    load_script();
    run_and_check("badch");
    clear_script();
    set_entry(0, 3'd1, 2'd1, 16'h0077, 0);
    set_entry(1, 3'd7, 2'd0, 16'h0000, 0);
    load_script();
    run_and_check("op7");
    clear_script();
    load_script();
    run_and_check("allnop");

    // Writes while running are dropped
    clear_script();
    set_entry(1, 3'd4, 2'd0, 16'd30, 0);
    set_entry(2, 3'd5, 2'd0, 16'h0000, 0);
    load_script();
    fork
      run_and_check("wrbusy");
      begin
        repeat (12) @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = {3'd1, 2'd0, 16'h1234};
        @(negedge clk);
        wr_en = 1'b0;
      end
    join

    // Abort during a long WAIT keeps channel values and raises no done
    clear_script();
    set_entry(0, 3'd1, 2'd1, 16'hABCD, 0);
    set_entry(1, 3'd4, 2'd0, 16'd1000, 0);
    set_entry(2, 3'd5, 2'd0, 16'h0000, 0);
    load_script();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    m_chan[1] = 16'hABCD;
    check_val("abort pre busy", 64'(busy), 64'(1));
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_quiet("abort wait");
    check_val("abort err", 64'(err), 64'(0));
    repeat (3) @(negedge clk);
    check_quiet("abort later");

    // Abort while a blocking send is pending drops the request
    clear_script();
    set_entry(0, 3'd3, 2'd0, 16'h0047, TIMEOUT + 50);
    load_script();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    m_cmd = 8'h47;
    check_val("abort blk send", 64'(send_cmd), 64'(1));
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_quiet("abort blk");

    // start and abort together: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check_quiet("start+abort");
    repeat (2) @(negedge clk);
    check_quiet("start+abort later");

    // Asynchronous reset in the middle of a blocking send
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check_val("prereset send", 64'(send_cmd), 64'(1));
    RST = 1'b1;
    #1;
    for (int k = 0; k < NCH; k++) m_chan[k] = '0;
    m_cmd = '0;
    check_quiet("midreset");
    check_val("midreset err", 64'(err), 64'(0));
    check_val("midreset pc",  64'(pc),  64'(0));
    @(negedge clk); RST = 1'b0;

    for (int r = 0; r < 12; r++) begin
      random_script(r < 2);
      load_script();
      run_and_check($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
